// File: rtl/loader_pkg.sv
// Shared definitions for the instruction memory loader: FSM states and stream framing.
package loader_pkg;

  localparam int DEF_ADDR_W = 15;
  localparam int DEF_DATA_W = 16;

  // LEN_HI, LEN_LO up front; one checksum byte at the end
  localparam int HDR_LEN = 2;
  localparam int CHK_LEN = 1;

  typedef enum logic [3:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/instr_mem_loader.sv
// Byte-stream loader for instruction memory. Assembles big-endian words, writes them
// to consecutive addresses, verifies an XOR checksum and releases the CPU hold.
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = (2 ** ADDR_W) - BASE_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       words_loaded
);

  state_t      state, state_next;
  logic [15:0] len;
  logic [7:0]  hi_byte;
  logic [7:0]  checksum;
  logic        accept;
  logic [15:0] len_cand;
  logic [15:0] words_inc;

  assign in_ready  = (state == LEN_HI) || (state == LEN_LO) || (state == DATA_HI) ||
                     (state == DATA_LO) || (state == CHECK);
  assign accept    = in_valid && in_ready;
  assign len_cand  = {len[15:8], in_data};
  assign words_inc = words_loaded + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    cpu_hold   = 1'b1;
    busy       = 1'b1;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = LEN_HI;
      end
      LEN_HI:  if (accept) state_next = LEN_LO;
      LEN_LO: begin
        if (accept) begin
          if (len_cand == 16'd0)                 state_next = CHECK;
          else if (int'(len_cand) > MAX_WORDS)   state_next = ERROR;
          else                                   state_next = DATA_HI;
        end
      end
      DATA_HI: if (accept) state_next = DATA_LO;
      DATA_LO: if (accept) state_next = WRITE;
      WRITE: begin
        mem_we     = 1'b1;
        state_next = (words_inc == len) ? CHECK : DATA_HI;
      end
      CHECK: begin
        if (accept) state_next = (in_data == checksum) ? DONE : ERROR;
      end
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        busy     = 1'b0;
        if (start) state_next = LEN_HI;
      end
      ERROR: begin
        err  = 1'b1;
        busy = 1'b0;
        if (start) state_next = LEN_HI;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len          <= '0;
      hi_byte      <= '0;
      checksum     <= '0;
      mem_addr     <= ADDR_W'(BASE_ADDR);
      mem_wdata    <= '0;
      words_loaded <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            checksum     <= '0;
            words_loaded <= '0;
            mem_addr     <= ADDR_W'(BASE_ADDR);
          end
        end
        LEN_HI: if (accept) len[15:8] <= in_data;
        LEN_LO: if (accept) len[7:0]  <= in_data;
        DATA_HI: begin
          if (accept) begin
            hi_byte  <= in_data;
            checksum <= checksum ^ in_data;
          end
        end
        DATA_LO: begin
          if (accept) begin
            mem_wdata <= DATA_W'({hi_byte, in_data});
            checksum  <= checksum ^ in_data;
          end
        end
        // address wraps naturally at the top of the ADDR_W space
        WRITE: begin
          mem_addr     <= mem_addr + 1'b1;
          words_loaded <= words_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected writes are queued by the stimulus and
// popped by per-instance monitors on every mem_we; status outputs are checked directly.
module tb_instr_mem_loader;

  typedef struct {
    logic [14:0] a;
    logic [15:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic v0 = 1'b0, v1 = 1'b0;
  logic [7:0] d0 = '0, d1 = '0;

  logic rdy0, we0, hold0, busy0, done0, err0;
  logic rdy1, we1, hold1, busy1, done1, err1;
  logic [14:0] addr0, addr1;
  logic [15:0] wd0, wd1, wl0, wl1;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int prev_wr = 0, last_wr = 0;
  wr_t q0[$];
  wr_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_mem_loader #(.BASE_ADDR(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .in_valid(v0), .in_data(d0),
    .in_ready(rdy0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0),
    .cpu_hold(hold0), .busy(busy0), .done(done0), .err(err0), .words_loaded(wl0)
  );

  instr_mem_loader #(.BASE_ADDR(32'h7FFF)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .in_valid(v1), .in_data(d1),
    .in_ready(rdy1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1),
    .cpu_hold(hold1), .busy(busy1), .done(done1), .err(err1), .words_loaded(wl1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (we0) begin
      prev_wr = last_wr;
      last_wr = cyc;
      compared++;
      if (q0.size() == 0) begin
        mismatched++;
        $display("FAIL dut0 unexpected write: addr %0h data %0h", addr0, wd0);
      end else begin
        wr_t e;
        e = q0.pop_front();
        if (addr0 !== e.a || wd0 !== e.d) begin
          mismatched++;
          $display("FAIL dut0 write: got %0h/%0h expected %0h/%0h", addr0, wd0, e.a, e.d);
        end
      end
    end
    if (we1) begin
      compared++;
      if (q1.size() == 0) begin
        mismatched++;
        $display("FAIL dut1 unexpected write: addr %0h data %0h", addr1, wd1);
      end else begin
        wr_t e;
        e = q1.pop_front();
        if (addr1 !== e.a || wd1 !== e.d) begin
          mismatched++;
          $display("FAIL dut1 write: got %0h/%0h expected %0h/%0h", addr1, wd1, e.a, e.d);
        end
      end
    end
  end

  task automatic push(input bit sel, input logic [14:0] a, input logic [15:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    if (sel) q1.push_back(e);
    else     q0.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input bit sel, input logic [7:0] b, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      if (sel) v1 = 1'b0; else v0 = 1'b0;
      @(negedge clk);
    end
    if (sel) begin v1 = 1'b1; d1 = b; end
    else     begin v0 = 1'b1; d0 = b; end
    n = 0;
    while (!(sel ? rdy1 : rdy0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      compared++;
      mismatched++;
      $display("FAIL in_ready timeout: got 0 expected 1 (byte %0h)", b);
    end else begin
      @(negedge clk);
    end
    if (sel) v1 = 1'b0; else v0 = 1'b0;
  endtask

  task automatic send_stream(input bit sel, input logic [7:0] bytes[$], input int max_gap);
    foreach (bytes[i]) send_byte(sel, bytes[i], $urandom_range(0, max_gap));
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start0 = 1'b0;
  endtask

  task automatic wait_term(input bit sel);
    int n;
    n = 0;
    while (!(sel ? (done1 || err1) : (done0 || err0)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      compared++;
      mismatched++;
      $display("FAIL terminal state timeout: got busy expected done/err");
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst cpu_hold", hold0, 1);
    check("rst in_ready", rdy0, 0);
    check("rst mem_we", we0, 0);
    check("rst done", done0, 0);
    check("rst err", err0, 0);
    check("rst busy", busy0, 0);
    check("rst mem_addr", addr0, 0);
    check("rst words_loaded", wl0, 0);
    check("rst dut1 mem_addr", addr1, 15'h7FFF);
    rst = 1'b0;
    @(negedge clk);
    check("idle in_ready", rdy0, 0);

    // Two-word load, no stalls
    pulse_start(0);
    check("start busy", busy0, 1);
    push(0, 15'h0000, 16'h1234);
    push(0, 15'h0001, 16'hABCD);
    send_stream(0, '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40}, 0);
    wait_term(0);
    check("load2 done", done0, 1);
    check("load2 err", err0, 0);
    check("load2 cpu_hold", hold0, 0);
    check("load2 busy", busy0, 0);
    check("load2 words_loaded", wl0, 2);
    check("load2 write spacing", last_wr - prev_wr, 3);

    // Same image, wrong checksum
    pulse_start(0);
    check("restart cpu_hold", hold0, 1);
    push(0, 15'h0000, 16'h1234);
    push(0, 15'h0001, 16'hABCD);
    send_stream(0, '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41}, 0);
    wait_term(0);
    check("badchk err", err0, 1);
    check("badchk done", done0, 0);
    check("badchk cpu_hold", hold0, 1);
    check("badchk words_loaded", wl0, 2);

    // Empty image
    pulse_start(0);
    send_stream(0, '{8'h00, 8'h00, 8'h00}, 0);
    wait_term(0);
    check("empty done", done0, 1);
    check("empty words_loaded", wl0, 0);

    // One word with random stalls
    pulse_start(0);
    push(0, 15'h0000, 16'h5AA5);
    send_stream(0, '{8'h00, 8'h01, 8'h5A, 8'hA5, 8'hFF}, 3);
    wait_term(0);
    check("stall done", done0, 1);
    check("stall words_loaded", wl0, 1);
    check("stall mem_addr", addr0, 1);

    // Abort in DATA_LO
    pulse_start(0);
    send_stream(0, '{8'h00, 8'h01, 8'h12}, 0);
    check("pre-abort in_ready", rdy0, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", busy0, 0);
    check("abort in_ready", rdy0, 0);
    check("abort cpu_hold", hold0, 1);
    check("abort done", done0, 0);

    // Restart with a start pulse mid-load
    pulse_start(0);
    push(0, 15'h0000, 16'h1122);
    push(0, 15'h0001, 16'h3344);
    send_stream(0, '{8'h00, 8'h02, 8'h11, 8'h22}, 0);
    pulse_start(0);
    check("midstart busy", busy0, 1);
    send_stream(0, '{8'h33, 8'h44, 8'h44}, 1);
    wait_term(0);
    check("restart done", done0, 1);
    check("restart words_loaded", wl0, 2);
    check("restart cpu_hold", hold0, 0);

    // BASE_ADDR=0x7FFF: oversize length
    pulse_start(1);
    send_stream(1, '{8'h00, 8'h02}, 0);
    check("oversize err", err1, 1);
    check("oversize in_ready", rdy1, 0);
    v1 = 1'b1;
    d1 = 8'hAA;
    repeat (3) @(negedge clk);
    v1 = 1'b0;
    check("oversize held in_ready", rdy1, 0);
    check("oversize held err", err1, 1);
    check("oversize cpu_hold", hold1, 1);

    // BASE_ADDR=0x7FFF: single word, address wraps
    pulse_start(1);
    push(1, 15'h7FFF, 16'hBEEF);
    send_stream(1, '{8'h00, 8'h01, 8'hBE, 8'hEF, 8'h51}, 0);
    wait_term(1);
    check("wrap done", done1, 1);
    check("wrap mem_addr", addr1, 0);
    check("wrap words_loaded", wl1, 1);

    repeat (3) @(negedge clk);
    check("dut0 queue drained", q0.size(), 0);
    check("dut1 queue drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
